act_unit_pipe: RTL and testbench

ACT_UNIT_PIPE -- requirements
Module: act_unit_pipe

---
 rtl/act_pkg.sv | 22 ++
 rtl/act_lane.sv | 79 +++++++
 rtl/act_unit_pipe.sv | 162 ++++++++++++++++
 tb/tb_act_unit_pipe.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/act_pkg.sv
// -----------------------------------------------------------------------------
// act_pkg -- shared definitions for the activation pipeline.
//
// Contents:
//   act_mode_e  : per-beat activation function encoding
//                 ACT_PASS (0), ACT_RELU (1), ACT_CLAMP (2), ACT_LEAKY (3)
//   ACT_MODE_W  : width of the mode field
//
// Build option: ACT_LEAKY_EN (see act_lane) enables the leaky-ReLU shifter.
// -----------------------------------------------------------------------------
package act_pkg;

  localparam int ACT_MODE_W = 2;

  typedef enum logic [ACT_MODE_W-1:0] {
    ACT_PASS  = 2'd0,
    ACT_RELU  = 2'd1,
    ACT_CLAMP = 2'd2,
    ACT_LEAKY = 2'd3
  } act_mode_e;

endpackage : act_pkg

// File: rtl/act_lane.sv
// -----------------------------------------------------------------------------
// act_lane -- combinational activation for one signed lane.
//
// Ports:
//   x_i        : signed input sample (DATA_WIDTH)
//   en_i       : beat enable; 0 forces the result to zero
//   mode_i     : activation function (act_mode_e encoding)
//   clamp_i    : clamp ceiling for ACT_CLAMP, expected non-negative
//   shift_i    : arithmetic right-shift amount for ACT_LEAKY
//   y_o        : activation result (DATA_WIDTH, never overflows)
//   clipped_o  : 1 when ACT_CLAMP replaced the sample by the ceiling
//
// Build option: ACT_LEAKY_EN defined -> ACT_LEAKY scales negative samples by
// 2^-shift (floor). Undefined -> no shifter, ACT_LEAKY behaves as ACT_RELU and
// shift_i is ignored.
// -----------------------------------------------------------------------------
module act_lane
  import act_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SHIFT_WIDTH = 3
) (
  input  logic [DATA_WIDTH-1:0]  x_i,
  input  logic                   en_i,
  input  logic [ACT_MODE_W-1:0]  mode_i,
  input  logic [DATA_WIDTH-1:0]  clamp_i,
  input  logic [SHIFT_WIDTH-1:0] shift_i,
  output logic [DATA_WIDTH-1:0]  y_o,
  output logic                   clipped_o
);

  logic signed [DATA_WIDTH-1:0] x_s;
  logic signed [DATA_WIDTH-1:0] clamp_s;
  logic                         x_pos;
  logic                         over_clamp;

  assign x_s        = $signed(x_i);
  assign clamp_s    = $signed(clamp_i);
  assign x_pos      = !x_i[DATA_WIDTH-1] && (|x_i);
  assign over_clamp = x_s > clamp_s;

`ifdef ACT_LEAKY_EN
  // Arithmetic shift floors toward minus infinity and can never leave the
  // lane range, so the most-negative value with shift 0 passes unchanged.
  logic signed [DATA_WIDTH-1:0] leaky_s;
  assign leaky_s = x_s >>> shift_i;
`else
  logic unused_shift;
  assign unused_shift = ^shift_i;
`endif

  always_comb begin
    y_o       = '0;
    clipped_o = 1'b0;
    if (en_i) begin
      case (act_mode_e'(mode_i))
        ACT_PASS:  y_o = x_i;
        ACT_RELU:  y_o = x_pos ? x_i : '0;
        ACT_CLAMP: begin
          if (!x_pos) begin
            y_o = '0;
          end else if (over_clamp) begin
            y_o       = clamp_i;
            clipped_o = 1'b1;
          end else begin
            y_o = x_i;
          end
        end
`ifdef ACT_LEAKY_EN
        ACT_LEAKY: y_o = x_i[DATA_WIDTH-1] ? leaky_s : x_i;
`else
        ACT_LEAKY: y_o = x_pos ? x_i : '0;
`endif
        default:   y_o = '0;
      endcase
    end
  end

endmodule : act_lane

// File: rtl/act_unit_pipe.sv
// -----------------------------------------------------------------------------
// act_unit_pipe -- two-stage valid/ready activation pipeline, NO_LANES lanes.
//
// Ports:
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready : input handshake
//   in_data           : packed lanes, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   in_en, mode       : per-beat enable and activation function
//   cfg_clamp         : ceiling for the clamped ReLU
//   cfg_shift         : leaky-ReLU shift amount
//   out_valid/out_ready : output handshake
//   out_data          : result lanes, same packing as in_data
//   cnt_clr           : synchronous clear of clip_cnt (wins over increment)
//   clip_cnt          : saturating count of lanes altered by clamping
//
// Stage 1 captures the beat together with its controls; the lane arithmetic
// sits between stage 1 and stage 2; stage 2 drives the outputs.
//
// Build option: ACT_LEAKY_EN enables the leaky-ReLU shifter (mode 3).
// -----------------------------------------------------------------------------
module act_unit_pipe
  import act_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int NO_LANES    = 8,
  parameter int SHIFT_WIDTH = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_WIDTH*NO_LANES-1:0] in_data,
  input  logic                           in_en,
  input  logic [1:0]                     mode,
  input  logic [DATA_WIDTH-1:0]          cfg_clamp,
  input  logic [SHIFT_WIDTH-1:0]         cfg_shift,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_WIDTH*NO_LANES-1:0] out_data,
  input  logic                           cnt_clr,
  output logic [31:0]                    clip_cnt
);

  localparam int BW = DATA_WIDTH * NO_LANES;

  // Stage 1: raw beat plus the controls sampled at acceptance
  logic                   s1_valid_q, s1_valid_d;
  logic [BW-1:0]          s1_data_q,  s1_data_d;
  logic                   s1_en_q,    s1_en_d;
  logic [ACT_MODE_W-1:0]  s1_mode_q,  s1_mode_d;
  logic [DATA_WIDTH-1:0]  s1_clamp_q, s1_clamp_d;
  logic [SHIFT_WIDTH-1:0] s1_shift;

  // Stage 2: computed results
  logic                   s2_valid_q, s2_valid_d;
  logic [BW-1:0]          s2_data_q,  s2_data_d;
  logic [31:0]            clip_cnt_q, clip_cnt_d;

  logic                   s1_adv;
  logic                   in_fire;
  logic                   s2_load;
  logic [BW-1:0]          lane_y;
  logic [NO_LANES-1:0]    lane_clip;
  logic [31:0]            clip_sum;
  logic [32:0]            cnt_sum;

  assign s1_adv   = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s1_adv;
  assign in_fire  = in_valid && in_ready;
  assign s2_load  = s1_valid_q && s1_adv;

`ifdef ACT_LEAKY_EN
  logic [SHIFT_WIDTH-1:0] s1_shift_q, s1_shift_d;

  assign s1_shift_d = in_fire ? cfg_shift : s1_shift_q;
  assign s1_shift   = s1_shift_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s1_shift_q <= '0;
    else        s1_shift_q <= s1_shift_d;
  end
`else
  // Without the shifter the shift amount is never stored.
  logic unused_cfg_shift;
  assign unused_cfg_shift = ^cfg_shift;
  assign s1_shift         = '0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NO_LANES; gi++) begin : g_lane
      act_lane #(
        .DATA_WIDTH (DATA_WIDTH),
        .SHIFT_WIDTH(SHIFT_WIDTH)
      ) u_lane (
        .x_i      (s1_data_q[gi*DATA_WIDTH +: DATA_WIDTH]),
        .en_i     (s1_en_q),
        .mode_i   (s1_mode_q),
        .clamp_i  (s1_clamp_q),
        .shift_i  (s1_shift),
        .y_o      (lane_y[gi*DATA_WIDTH +: DATA_WIDTH]),
        .clipped_o(lane_clip[gi])
      );
    end
  endgenerate

  always_comb begin
    clip_sum = '0;
    for (int i = 0; i < NO_LANES; i++) begin
      clip_sum = clip_sum + 32'(lane_clip[i]);
    end
  end

  assign cnt_sum = {1'b0, clip_cnt_q} + {1'b0, clip_sum};

  always_comb begin
    // S1 fills on acceptance, empties when it hands its beat to S2.
    s1_valid_d = in_fire ? 1'b1 : (s2_load ? 1'b0 : s1_valid_q);
    s1_data_d  = in_fire ? in_data   : s1_data_q;
    s1_en_d    = in_fire ? in_en     : s1_en_q;
    s1_mode_d  = in_fire ? mode      : s1_mode_q;
    s1_clamp_d = in_fire ? cfg_clamp : s1_clamp_q;

    // When S2 may advance it takes whatever S1 holds (possibly a bubble).
    s2_valid_d = s1_adv  ? s1_valid_q : s2_valid_q;
    s2_data_d  = s2_load ? lane_y     : s2_data_q;

    clip_cnt_d = clip_cnt_q;
    if (cnt_clr) begin
      clip_cnt_d = '0;
    end else if (s2_load) begin
      clip_cnt_d = cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_en_q    <= 1'b0;
      s1_mode_q  <= '0;
      s1_clamp_q <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      clip_cnt_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_en_q    <= s1_en_d;
      s1_mode_q  <= s1_mode_d;
      s1_clamp_q <= s1_clamp_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      clip_cnt_q <= clip_cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign clip_cnt  = clip_cnt_q;

endmodule : act_unit_pipe

// File: tb/tb_act_unit_pipe.sv
module tb_act_unit_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_en;
  logic [1:0]  mode;
  logic [7:0]  cfg_clamp;
  logic [2:0]  cfg_shift;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        cnt_clr;
  logic [31:0] clip_cnt;

  int checks   = 0;
  int failures = 0;
  int rx_count = 0;
  int cyc      = 0;
  int exp_clip = 0;

  logic [63:0] exp_q[$];

  act_unit_pipe #(
    .DATA_WIDTH (8),
    .NO_LANES   (8),
    .SHIFT_WIDTH(3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_en    (in_en),
    .mode     (mode),
    .cfg_clamp(cfg_clamp),
    .cfg_shift(cfg_shift),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .cnt_clr  (cnt_clr),
    .clip_cnt (clip_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic void chk(input bit ok, input string nm,
                              input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endfunction

  // Reference: each lane evaluated from the activation rules with integer math.
  function automatic void model(input logic [63:0] d, input bit en, input int m,
                                input int c, input int s,
                                output logic [63:0] y, output int clips);
    y = '0;
    clips = 0;
    for (int k = 0; k < 8; k++) begin
      int x;
      int r;
      x = $signed(d[k*8 +: 8]);
      r = 0;
      if (en) begin
        case (m)
          0: r = x;
          1: r = (x > 0) ? x : 0;
          2: begin
            if (x <= 0) r = 0;
            else if (x > c) begin r = c; clips++; end
            else r = x;
          end
          default: begin
`ifdef ACT_LEAKY_EN
            if (x >= 0) r = x;
            else r = -(((-x) + (1 << s) - 1) / (1 << s));
`else
            r = (x > 0) ? x : 0;
`endif
          end
        endcase
      end
      y[k*8 +: 8] = r[7:0];
    end
  endfunction

  function automatic logic [63:0] pack(input int v[8]);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r[k*8 +: 8] = v[k][7:0];
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [63:0] d, input bit en, input int m,
                      input int c, input int s,
                      input bit use_lit, input logic [63:0] lit);
    int w;
    logic [63:0] y;
    int clips;
    in_valid  = 1'b1;
    in_data   = d;
    in_en     = en;
    mode      = m[1:0];
    cfg_clamp = c[7:0];
    cfg_shift = s[2:0];
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk(in_ready, "send_accept", {63'd0, in_ready}, 64'd1);
    model(d, en, m, c, s, y, clips);
    exp_q.push_back(use_lit ? lit : y);
    exp_clip += clips;
    @(posedge clk);
    #1;
    // Scramble idle inputs: the in-flight beat must not depend on them.
    in_valid  = 1'b0;
    in_data   = {$urandom, $urandom};
    in_en     = 1'($urandom);
    mode      = 2'($urandom);
    cfg_clamp = 8'($urandom);
    cfg_shift = 3'($urandom);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    chk(exp_q.size() == 0, "drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops and compares every accepted output beat, checks holding.
  initial begin
    bit          hold_v;
    logic [63:0] hold_d;
    logic [63:0] e;
    hold_v = 1'b0;
    hold_d = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) chk(out_valid && out_data == hold_d, "hold_stable", out_data, hold_d);
        if (out_valid && !out_ready) begin
          hold_v = 1'b1;
          hold_d = out_data;
        end else begin
          hold_v = 1'b0;
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk(1'b0, "unexpected_beat", out_data, 64'd0);
          end else begin
            e = exp_q.pop_front();
            rx_count++;
            chk(out_data == e, "beat_data", out_data, e);
            $display("beat %0d out=%h exp=%h clip_cnt=%0d", rx_count, out_data, e, clip_cnt);
          end
        end
      end
    end
  end

  initial begin
    int v[8];
    int t0;
    int rx0;
    int base;
    bit rnd_done;
    logic [63:0] lit;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_en = 1'b0; mode = '0;
    cfg_clamp = '0; cfg_shift = '0; out_ready = 1'b1; cnt_clr = 1'b0;

    repeat (2) @(negedge clk);
    chk(!out_valid, "rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk(out_data == 64'd0, "rst_out_data", out_data, 64'd0);
    chk(clip_cnt == 32'd0, "rst_clip_cnt", 64'(clip_cnt), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk(in_ready, "rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;

    // ReLU vector, with latency check
    v = '{-5, 0, 7, 127, -128, 1, -1, 64};
    lit = pack('{0, 0, 7, 127, 0, 1, 0, 64});
    send(pack(v), 1'b1, 1, 0, 0, 1'b1, lit);
    @(negedge clk);
    chk(!out_valid, "latency_1cyc", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    chk(out_valid, "latency_2cyc", {63'd0, out_valid}, 64'd1);
    @(posedge clk); #1;
    drain();

    // Clamped ReLU vector
    base = exp_clip;
    v = '{-3, 3, 6, 7, 100, 0, 5, 127};
    send(pack(v), 1'b1, 2, 6, 0, 1'b1, pack('{0, 3, 6, 6, 6, 0, 5, 6}));
    drain();
    chk(clip_cnt == 32'(base + 3), "clamp_clip_cnt", 64'(clip_cnt), 64'(base + 3));

    // Leaky ReLU vector
    v = '{-8, -1, -128, 5, 0, 0, 0, 0};
`ifdef ACT_LEAKY_EN
    lit = pack('{-2, -1, -32, 5, 0, 0, 0, 0});
`else
    lit = pack('{0, 0, 0, 5, 0, 0, 0, 0});
`endif
    send(pack(v), 1'b1, 3, 0, 2, 1'b1, lit);
    v = '{-128, -7, 9, -1, 0, 0, 0, 0};
    send(pack(v), 1'b1, 3, 0, 0, 1'b0, '0);
    drain();

    // Enable low overrides pass mode
    send(64'h5555_5555_5555_5555, 1'b0, 0, 0, 0, 1'b1, 64'd0);
    drain();

    // Sustained throughput
    t0 = cyc;
    for (int i = 0; i < 8; i++)
      send({$urandom, $urandom}, 1'b1, int'($urandom_range(0, 3)),
           int'($urandom_range(0, 127)), int'($urandom_range(0, 7)), 1'b0, '0);
    chk(cyc - t0 == 8, "throughput_cycles", 64'(cyc - t0), 64'd8);
    drain();

    // Backpressure with 6 beats
    rx0 = rx_count;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send({$urandom, $urandom}, 1'b1, int'($urandom_range(0, 3)),
               int'($urandom_range(0, 127)), int'($urandom_range(0, 7)), 1'b0, '0);
      end
      begin
        repeat (4) @(negedge clk);
        chk(!in_ready, "bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        chk(out_valid, "bp_out_valid", {63'd0, out_valid}, 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk(rx_count - rx0 == 6, "bp_beat_count", 64'(rx_count - rx0), 64'd6);
    chk(clip_cnt == 32'(exp_clip), "clip_cnt_total", 64'(clip_cnt), 64'(exp_clip));

    // Clear coincident with a clipping beat loading S2
    v = '{-3, 3, 6, 7, 100, 0, 5, 127};
    send(pack(v), 1'b1, 2, 6, 0, 1'b1, pack('{0, 3, 6, 6, 6, 0, 5, 6}));
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    exp_clip = 0;
    @(negedge clk);
    chk(clip_cnt == 32'd0, "cnt_clr_priority", 64'(clip_cnt), 64'd0);
    @(posedge clk); #1;
    drain();

    // Reset with two beats in flight
    rx0 = rx_count;
    send(pack(v), 1'b1, 2, 6, 0, 1'b0, '0);
    send(pack(v), 1'b1, 2, 6, 0, 1'b0, '0);
    rst_n = 1'b0;
    #1;
    chk(!out_valid, "midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk(clip_cnt == 32'd0, "midrst_clip_cnt", 64'(clip_cnt), 64'd0);
    chk(out_data == 64'd0, "midrst_out_data", out_data, 64'd0);
    exp_q.delete();
    exp_clip = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk(in_ready, "postrst_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (5) @(negedge clk);
    chk(rx_count == rx0, "postrst_no_stale", 64'(rx_count), 64'(rx0));
    @(posedge clk); #1;

    // Randomized traffic with random backpressure
    rnd_done = 1'b0;
    rx0 = rx_count;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          if ($urandom_range(0, 7) == 0) begin
            @(posedge clk); #1;
          end
          send({$urandom, $urandom}, $urandom_range(0, 9) != 0,
               int'($urandom_range(0, 3)), int'($urandom_range(0, 127)),
               int'($urandom_range(0, 7)), 1'b0, '0);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 9) < 7);
        end
      end
    join
    out_ready = 1'b1;
    drain();
    chk(rx_count - rx0 == 200, "rand_beat_count", 64'(rx_count - rx0), 64'd200);
    chk(clip_cnt == 32'(exp_clip), "rand_clip_cnt", 64'(clip_cnt), 64'(exp_clip));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_act_unit_pipe
